// File: rtl/intersection_controller.sv
// intersection_controller
// Two-road traffic controller: major road NS, minor road EW served on demand.
// It sequences green, yellow and all-red phases and counts each dwell in ticks.
// A maintenance flash mode overrides the normal sequence.
// Light codes: 100 = red, 010 = yellow, 001 = green.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   tick      one-cycle timebase strobe; every dwell counts ticks
//   ew_car    EW vehicle sensor (level or pulse)
//   ped_req   pedestrian request (level or pulse)
//   flash_en  maintenance flash enable
//   ns_lights NS signal head code
//   ew_lights EW signal head code
//   walk      pedestrian walk for the EW crossing
//   phase     current state encoding (debug)
module intersection_controller #(
  parameter int CNT_W        = 8,
  parameter int NS_MIN_GREEN = 20,
  parameter int EW_GREEN     = 10,
  parameter int YELLOW_T     = 3,
  parameter int ALLRED_T     = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       ew_car,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic [2:0] ns_lights,
  output logic [2:0] ew_lights,
  output logic       walk,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_NS_GREEN  = 3'd0,
    S_NS_YELLOW = 3'd1,
    S_ALLRED_A  = 3'd2,
    S_EW_GREEN  = 3'd3,
    S_EW_YELLOW = 3'd4,
    S_ALLRED_B  = 3'd5,
    S_FLASH     = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] NS_LAST  = CNT_W'(NS_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] EWG_LAST = CNT_W'(EW_GREEN - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALLRED_T - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             car_l_reg, car_l_next;
  logic             ped_l_reg, ped_l_next;
  logic             walk_reg, walk_next;
  logic             blink_reg, blink_next;

  // Terminal count and successor of the current state.
  logic [CNT_W-1:0] dwell_last;
  state_t           succ;

  always_comb begin
    dwell_last = '0;
    succ       = S_ALLRED_B;
    case (state_reg)
      S_NS_GREEN:  begin dwell_last = NS_LAST;  succ = S_NS_YELLOW; end
      S_NS_YELLOW: begin dwell_last = Y_LAST;   succ = S_ALLRED_A;  end
      S_ALLRED_A:  begin dwell_last = AR_LAST;  succ = S_EW_GREEN;  end
      S_EW_GREEN:  begin dwell_last = EWG_LAST; succ = S_EW_YELLOW; end
      S_EW_YELLOW: begin dwell_last = Y_LAST;   succ = S_ALLRED_B;  end
      S_ALLRED_B:  begin dwell_last = AR_LAST;  succ = S_NS_GREEN;  end
      default:     begin dwell_last = '0;       succ = S_ALLRED_B;  end
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    car_l_next = car_l_reg | ew_car;
    ped_l_next = ped_l_reg | ped_req;
    walk_next  = walk_reg;
    blink_next = blink_reg;

    if (flash_en && state_reg != S_FLASH) begin
      // Flash entry discards any coincident tick and wipes all context.
      state_next = S_FLASH;
      cnt_next   = '0;
      car_l_next = 1'b0;
      ped_l_next = 1'b0;
      blink_next = 1'b0;
    end else if (state_reg == S_FLASH) begin
      // Demand is not recorded while flashing.
      car_l_next = 1'b0;
      ped_l_next = 1'b0;
      if (flash_en) begin
        blink_next = blink_reg ^ tick;
      end else begin
        state_next = S_ALLRED_B;
        cnt_next   = '0;
        blink_next = 1'b0;
      end
    end else if (tick) begin
      if (cnt_reg == dwell_last) begin
        // NS green holds at its saturated count until there is demand.
        if (state_reg != S_NS_GREEN || car_l_reg || ped_l_reg) begin
          state_next = succ;
          cnt_next   = '0;
        end
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end

    // Entering EW green: walk takes the pending pedestrian request, and the
    // latches restart from this cycle's inputs so set wins over clear.
    if (state_next == S_EW_GREEN && state_reg != S_EW_GREEN) begin
      walk_next  = ped_l_reg;
      car_l_next = ew_car;
      ped_l_next = ped_req;
    end else if (state_next != S_EW_GREEN) begin
      walk_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= S_ALLRED_B;
      cnt_reg   <= '0;
      car_l_reg <= 1'b0;
      ped_l_reg <= 1'b0;
      walk_reg  <= 1'b0;
      blink_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      car_l_reg <= car_l_next;
      ped_l_reg <= ped_l_next;
      walk_reg  <= walk_next;
      blink_reg <= blink_next;
    end
  end

  // Heads decode only from registers, so they never glitch.
  always_comb begin
    ns_lights = 3'b100;
    ew_lights = 3'b100;
    case (state_reg)
      S_NS_GREEN:  ns_lights = 3'b001;
      S_NS_YELLOW: ns_lights = 3'b010;
      S_EW_GREEN:  ew_lights = 3'b001;
      S_EW_YELLOW: ew_lights = 3'b010;
      S_FLASH: begin
        ns_lights = blink_reg ? 3'b010 : 3'b000;
        ew_lights = blink_reg ? 3'b100 : 3'b000;
      end
      default: begin
        ns_lights = 3'b100;
        ew_lights = 3'b100;
      end
    endcase
  end

  assign walk  = walk_reg;
  assign phase = state_reg;

endmodule

// File: tb/tb_intersection_controller.sv
// Testbench for intersection_controller: scenario tasks plus a randomized run,
// all compared against a phase/tick-count reference model of the controller.
module tb_intersection_controller;

  localparam int MIN_G = 4;
  localparam int EW_G  = 3;
  localparam int YEL   = 2;
  localparam int AR    = 1;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       ew_car = 1'b0;
  logic       ped_req = 1'b0;
  logic       flash_en = 1'b0;
  logic [2:0] ns_lights;
  logic [2:0] ew_lights;
  logic       walk;
  logic [2:0] phase;

  int checks = 0;
  int errors = 0;
  int tick_cnt = 0;

  // Reference model: current phase number, ticks spent in it, pending demands.
  int   m_phase = 5;
  int   m_n = 0;
  logic m_car = 1'b0;
  logic m_ped = 1'b0;
  logic m_walk = 1'b0;
  logic m_blink = 1'b0;
  int   dur [6] = '{MIN_G, YEL, AR, EW_G, YEL, AR};

  intersection_controller #(
    .CNT_W(8), .NS_MIN_GREEN(MIN_G), .EW_GREEN(EW_G), .YELLOW_T(YEL), .ALLRED_T(AR)
  ) dut (
    .clk(clk), .reset(reset), .tick(tick), .ew_car(ew_car), .ped_req(ped_req),
    .flash_en(flash_en), .ns_lights(ns_lights), .ew_lights(ew_lights),
    .walk(walk), .phase(phase)
  );

  always #5 clk = ~clk;

  task automatic model_step(input logic r, input logic f, input logic t,
                            input logic c, input logic p);
    logic old_ped;
    logic entered;
    if (r) begin
      m_phase = 5; m_n = 0; m_car = 0; m_ped = 0; m_walk = 0; m_blink = 0;
    end else if (f && m_phase != 6) begin
      m_phase = 6; m_n = 0; m_car = 0; m_ped = 0; m_walk = 0; m_blink = 0;
    end else if (m_phase == 6) begin
      if (f) begin
        if (t) m_blink = !m_blink;
      end else begin
        m_phase = 5; m_n = 0; m_blink = 0;
      end
    end else begin
      old_ped = m_ped;
      entered = 1'b0;
      if (t) begin
        if (m_n + 1 < dur[m_phase]) m_n++;
        else if (m_phase != 0 || m_car || m_ped) begin
          m_phase = (m_phase + 1) % 6;
          m_n = 0;
          entered = (m_phase == 3);
        end
      end
      if (entered) begin
        m_car = 0; m_ped = 0; m_walk = old_ped;
      end else if (m_phase != 3) begin
        m_walk = 0;
      end
      m_car = m_car | c;
      m_ped = m_ped | p;
    end
  endtask

  // Expected {phase, ns, ew, walk} from the model.
  function automatic logic [9:0] exp_vec();
    logic [2:0] ns;
    logic [2:0] ew;
    ns = 3'b100;
    ew = 3'b100;
    case (m_phase)
      0: ns = 3'b001;
      1: ns = 3'b010;
      3: ew = 3'b001;
      4: ew = 3'b010;
      6: begin
        ns = m_blink ? 3'b010 : 3'b000;
        ew = m_blink ? 3'b100 : 3'b000;
      end
      default: ;
    endcase
    return {3'(m_phase), ns, ew, m_walk};
  endfunction

  // One clock: drive inputs, step the model with what the DUT sampled.
  task automatic cyc(input logic c, input logic p, input logic f,
                     input logic r, input logic ft);
    ew_car = c; ped_req = p; flash_en = f; reset = r;
    tick = ft | (tick_cnt == 3);
    @(posedge clk);
    model_step(r, f, tick, c, p);
    tick_cnt = (tick_cnt + 1) % 4;
    #1;
  endtask

  task automatic run_ticks(input int n);
    int seen = 0;
    while (seen < n) begin
      if (tick_cnt == 3) seen++;
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({phase, ns_lights, ew_lights, walk} !== {3'd5, 3'b100, 3'b100, 1'b0}) begin
      errors++; $display("FAIL reset_state: got %b exp %b", {phase, ns_lights, ew_lights, walk}, {3'd5, 3'b100, 3'b100, 1'b0});
    end
    run_ticks(1);
    checks++;
    if ({phase, ns_lights, ew_lights} !== {3'd0, 3'b001, 3'b100}) begin
      errors++; $display("FAIL reset_first_tick: got %b exp %b", {phase, ns_lights, ew_lights}, {3'd0, 3'b001, 3'b100});
    end
    $display("test_reset done");
  endtask

  task automatic test_no_demand();
    for (int i = 0; i < 12; i++) begin
      run_ticks(1);
      checks++;
      if ({phase, ns_lights} !== {3'd0, 3'b001}) begin
        errors++; $display("FAIL no_demand tick %0d: got %b exp %b", i, {phase, ns_lights}, {3'd0, 3'b001});
      end
    end
    $display("test_no_demand done");
  endtask

  task automatic test_car_cycle();
    int exp_ph [7] = '{0, 1, 2, 3, 4, 5, 0};
    int ticks  [7] = '{3, 1, 2, 1, 3, 2, 1};
    do_reset();
    run_ticks(1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int s = 0; s < 7; s++) begin
      run_ticks(ticks[s]);
      checks++;
      if (phase !== 3'(exp_ph[s])) begin
        errors++; $display("FAIL car_cycle step %0d: phase got %0d exp %0d", s, phase, exp_ph[s]);
      end
      if (exp_ph[s] == 3) begin
        checks++;
        if ({ew_lights, walk} !== {3'b001, 1'b0}) begin
          errors++; $display("FAIL car_ew_green: got %b exp %b", {ew_lights, walk}, {3'b001, 1'b0});
        end
      end
    end
    $display("test_car_cycle done");
  endtask

  task automatic test_ped();
    int k;
    int ew_cycles;
    logic first;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (k = 0; k < 100 && phase !== 3'd3; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({phase, ns_lights, ew_lights, walk} !== exp_vec()) begin
        errors++; $display("FAIL ped_approach: got %b exp %b", {phase, ns_lights, ew_lights, walk}, exp_vec());
      end
    end
    ew_cycles = 0;
    first = 1'b1;
    for (k = 0; k < 100 && phase === 3'd3; k++) begin
      checks++;
      if (walk !== 1'b1) begin
        errors++; $display("FAIL ped_walk: got %b exp 1", walk);
      end
      ew_cycles++;
      cyc(1'b0, first, 1'b0, 1'b0, 1'b0);
      first = 1'b0;
    end
    checks++;
    if (ew_cycles !== EW_G * 4) begin
      errors++; $display("FAIL ped_walk_len: got %0d exp %0d", ew_cycles, EW_G * 4);
    end
    for (k = 0; k < 200 && phase !== 3'd3; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({phase, ns_lights, ew_lights, walk} !== exp_vec()) begin
        errors++; $display("FAIL ped_second: got %b exp %b", {phase, ns_lights, ew_lights, walk}, exp_vec());
      end
    end
    checks++;
    if ({phase, walk} !== {3'd3, 1'b1}) begin
      errors++; $display("FAIL ped_second_walk: got %b exp %b", {phase, walk}, {3'd3, 1'b1});
    end
    $display("test_ped done");
  endtask

  task automatic test_flash();
    int k;
    logic saw_on = 1'b0;
    logic saw_off = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (k = 0; k < 200 && phase !== 3'd3; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({phase, walk} !== {3'd6, 1'b0}) begin
      errors++; $display("FAIL flash_entry: got %b exp %b", {phase, walk}, {3'd6, 1'b0});
    end
    for (k = 0; k < 14; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      if (ns_lights === 3'b010 && ew_lights === 3'b100) saw_on = 1'b1;
      if (ns_lights === 3'b000 && ew_lights === 3'b000) saw_off = 1'b1;
      checks++;
      if ({phase, ns_lights, ew_lights, walk} !== exp_vec()) begin
        errors++; $display("FAIL flash_blink: got %b exp %b", {phase, ns_lights, ew_lights, walk}, exp_vec());
      end
    end
    checks++;
    if ({saw_on, saw_off} !== 2'b11) begin
      errors++; $display("FAIL flash_toggle: got %b exp 11", {saw_on, saw_off});
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({phase, ns_lights, ew_lights} !== {3'd5, 3'b100, 3'b100}) begin
      errors++; $display("FAIL flash_exit: got %b exp %b", {phase, ns_lights, ew_lights}, {3'd5, 3'b100, 3'b100});
    end
    run_ticks(1);
    checks++;
    if (phase !== 3'd0) begin
      errors++; $display("FAIL flash_resume: phase got %0d exp 0", phase);
    end
    run_ticks(10);
    checks++;
    if ({phase, ns_lights} !== {3'd0, 3'b001}) begin
      errors++; $display("FAIL flash_latches_cleared: got %b exp %b", {phase, ns_lights}, {3'd0, 3'b001});
    end
    $display("test_flash done");
  endtask

  task automatic test_simultaneous();
    int k;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (k = 0; k < 200 && phase !== 3'd4; k++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (phase !== 3'd4) begin
      errors++; $display("FAIL simul_reach_ew_yellow: phase got %0d exp 4", phase);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    checks++;
    if ({phase, ns_lights, ew_lights, walk} !== {3'd5, 3'b100, 3'b100, 1'b0}) begin
      errors++; $display("FAIL simul_reset: got %b exp %b", {phase, ns_lights, ew_lights, walk}, {3'd5, 3'b100, 3'b100, 1'b0});
    end
    tick_cnt = 0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (phase !== 3'd5) begin
      errors++; $display("FAIL simul_no_flash: phase got %0d exp 5", phase);
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_random();
    logic f = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      if ($urandom_range(0, 79) == 0) f = !f;
      cyc(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 14) == 0), f,
          1'($urandom_range(0, 399) == 0), 1'b0);
      checks++;
      if ({phase, ns_lights, ew_lights, walk} !== exp_vec()) begin
        errors++; $display("FAIL random cycle %0d: got %b exp %b", i, {phase, ns_lights, ew_lights, walk}, exp_vec());
      end
      checks++;
      if (phase !== 3'd6 && ns_lights !== 3'b100 && ew_lights !== 3'b100) begin
        errors++; $display("FAIL safety cycle %0d: ns %b ew %b", i, ns_lights, ew_lights);
      end
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_no_demand();
    test_car_cycle();
    test_ped();
    test_flash();
    test_simultaneous();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/intersection_controller.md
# intersection_controller

Sequences a two-road intersection (major road NS, minor road EW) through green, yellow and all-red phases using tick-based dwell timers. EW is served only on demand from a vehicle sensor or pedestrian button. A maintenance flash mode overrides normal sequencing. The block sits above the per-approach signal heads and drives their 3-bit light codes directly: 100 = red, 010 = yellow, 001 = green.

## Interface
- `CNT_W`, 8: dwell counter width; every duration parameter must be below 2^CNT_W.
- `NS_MIN_GREEN`, 20: minimum NS green, in ticks (≥1).
- `EW_GREEN`, 10: EW green duration, in ticks (≥1).
- `YELLOW_T`, 3: yellow duration for either road, in ticks (≥1).
- `ALLRED_T`, 1: all-red clearance duration, in ticks (≥1).
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle timebase strobe; all dwell timing counts ticks.
- `ew_car`  in  1  EW vehicle sensor; level or pulse.
- `ped_req`  in  1  pedestrian crossing request; level or pulse.
- `flash_en`  in  1  maintenance flash mode enable.
- `ns_lights`  out  3  NS signal head code.
- `ew_lights`  out  3  EW signal head code.
- `walk`  out  1  pedestrian walk indication for the EW crossing.
- `phase`  out  3  current state encoding, for debug and monitoring.

## Operation
- **States and `phase` encoding:**
  - 0 NS_GREEN (ns=001, ew=100)
  - 1 NS_YELLOW (ns=010, ew=100)
  - 2 ALLRED_A (100/100)
  - 3 EW_GREEN (100/001)
  - 4 EW_YELLOW (100/010)
  - 5 ALLRED_B (100/100)
  - 6 FLASH
- **Reset values:** state ALLRED_B, dwell count 0, all demand latches 0, walk 0, blink 0, ns_lights=100, ew_lights=100, phase=5.
- **Dwell counter:** increments only on `tick`. When `tick` arrives with count == T-1 and the exit condition holds, the state advances and the count clears to 0.
- **NS_GREEN:** the count saturates at NS_MIN_GREEN-1. The state exits only on a `tick` where the count is saturated and a demand latch (car_l or ped_l) is set. With no demand it holds indefinitely.
- **Fixed-duration states:** NS_YELLOW→ALLRED_A after YELLOW_T, ALLRED_A→EW_GREEN after ALLRED_T, EW_GREEN→EW_YELLOW after EW_GREEN, EW_YELLOW→ALLRED_B after YELLOW_T, ALLRED_B→NS_GREEN after ALLRED_T.
- **Demand latches:**
  - car_l is set by `ew_car`; ped_l is set by `ped_req`. Either can be set on any cycle outside FLASH.
  - Both latches clear on the cycle the state enters EW_GREEN.
  - Set has priority over clear, so a request in the entry cycle or later is kept for the next EW service.
- **walk:** on entry to EW_GREEN, `walk` loads the pre-clear value of ped_l. It deasserts on exit from EW_GREEN and is never 1 in any other state.
- **FLASH:**
  - Entry: `flash_en` high at a clock edge forces the next state to FLASH from any state; count, latches, blink and walk clear.
  - While in FLASH, blink toggles on each `tick`; ns_lights = blink?010:000 and ew_lights = blink?100:000.
  - Exit: `flash_en` low while in FLASH moves to ALLRED_B with count 0, so the normal sequence resumes via all-red clearance.
- **Safety invariant:** ns_lights and ew_lights are never both non-red outside FLASH.

## Timing
- State, count, latches, blink and walk are registered. ns_lights, ew_lights and phase are decoded from the state register, so they change one cycle after the qualifying edge and are glitch-free.
- Exactly one transition occurs per qualifying tick; with `tick` low, nothing advances except the demand latches.
- **Priority at a clock edge:** `reset` > `flash_en` > tick-driven transition. A `tick` coinciding with `reset` or with FLASH entry is discarded.
- A reset in mid-sequence, e.g. during EW_YELLOW, takes effect at that edge. The next cycle shows phase 5 with both heads red and walk 0.
- **Minimum cycle from demand to EW green:** the remainder of NS_MIN_GREEN, plus YELLOW_T + ALLRED_T ticks.

## Test plan
Bench parameters: NS_MIN_GREEN=4, EW_GREEN=3, YELLOW_T=2, ALLRED_T=1, one tick every 4 clocks.
- **Reset exit:** release reset → phase=5, ns=ew=100, walk=0. After the 1st tick, phase=0, ns=001, ew=100.
- **No demand:** with no demand, apply 12 ticks → phase stays 0 and ns_lights stays 001.
- **Vehicle demand, full cycle:** pulse `ew_car` for one clock after the 1st green tick. Required phases:
  - phase 1 after the 4th tick, then phase 2 after 2 more ticks;
  - phase 3 (ew=001, walk=0) after 1 more tick;
  - phase 4 after 3 ticks, phase 5 after 2, phase 0 after 1.
- **Pedestrian demand:** pulse `ped_req` during NS_GREEN → walk=1 for exactly the 3-tick EW_GREEN. A second `ped_req` during EW_GREEN → a further EW service with walk=1 on the next cycle.
- **Flash override:** assert `flash_en` during EW_GREEN → next cycle phase=6 and walk=0, with ns toggling 010/000 and ew toggling 100/000 per tick. Deassert → phase=5, then phase 0 after 1 tick, and NS holds green with latches cleared.
- **Simultaneous events:** `reset` asserted in EW_YELLOW together with `tick` and `flash_en` → next cycle phase=5, both heads 100, and no FLASH entry.
